acc_cpu_core: RTL and testbench

- Parametrised next-generation accumulator CPU core.
- Merges the program counter, instruction register, accumulator, ALU and multi-cycle controller into one block.
- Talks to an external single-port memory through a req/ack handshake, so memory may insert wait states.
- Adds a carry flag, halt/resume control and debug visibility of PC, accumulator and FSM state.

---
 rtl/acc_cpu_core_if.sv | 27 ++
 rtl/acc_cpu_core.sv | 149 ++++++++++++++
 tb/tb_acc_cpu_core.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_cpu_core_if : memory req/ack bus between the core and external memory   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface acc_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/acc_cpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_cpu_core : multi-cycle accumulator CPU with req/ack memory port         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module acc_cpu_core #(
    parameter int DATA_W       = 8,
    parameter int OP_W         = 3,
    parameter int ADDR_W       = 5,
    parameter bit START_HALTED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    acc_cpu_core_if.master     mem,
    output logic               halted_o,
    output logic               zero_o,
    output logic               carry_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [DATA_W-1:0]  acc_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [OP_W-1:0]   OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0]   OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0]   OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0]   OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0]   OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0]   OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0]   OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0]   OP_JMP = OP_W'(7);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] ir_q,    ir_d;
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic              carry_q, carry_d;

    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [OP_W-1:0]   w_op;
    logic [ADDR_W-1:0] w_ir_addr;
    logic [DATA_W:0]   w_sum;

    assign w_op      = ir_q[DATA_W-1 -: OP_W];
    assign w_ir_addr = ir_q[ADDR_W-1:0];
    assign w_sum     = {1'b0, acc_q} + {1'b0, mem.mem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    // Bus outputs are decoded from registered state only, so a held access
    // keeps req/we/addr/wdata stable for as long as ack stays low.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_addr  = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = START_HALTED ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_addr = w_ir_addr;
                case (w_op)
                    OP_HLT: state_d = ST_HALT;
                    OP_SKZ: begin
                        if (acc_q == '0) begin
                            pc_d = pc_q + PC_ONE;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = w_ir_addr;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        w_req = 1'b1;
                        w_we  = (w_op == OP_STO);
                        if (mem.mem_ack) begin
                            state_d = ST_FETCH;
                            case (w_op)
                                OP_ADD:  {carry_d, acc_d} = w_sum;
                                OP_AND:  acc_d = acc_q & mem.mem_rdata;
                                OP_XOR:  acc_d = acc_q ^ mem.mem_rdata;
                                OP_LDA:  acc_d = mem.mem_rdata;
                                default: acc_d = acc_q;
                            endcase
                        end
                    end
                endcase
            end
            ST_HALT: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = acc_q;

    assign halted_o = (state_q == ST_HALT);
    assign zero_o   = (acc_q == '0);
    assign carry_o  = carry_q;
    assign pc_o     = pc_q;
    assign acc_o    = acc_q;
    assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acc_cpu_core : random and directed programs against an ISA-level model   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_acc_cpu_core;
    localparam int DW = 8;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic run0  = 1'b0;
    logic run1  = 1'b0;

    acc_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    acc_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    logic          halted0, zero0, carry0, halted1, zero1, carry1;
    logic [AW-1:0] pc0, pc1;
    logic [DW-1:0] acc0, acc1;
    logic [1:0]    state0, state1;

    acc_cpu_core #(.DATA_W(DW), .OP_W(3), .ADDR_W(AW), .START_HALTED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run_i(run0), .mem(bus0),
        .halted_o(halted0), .zero_o(zero0), .carry_o(carry0),
        .pc_o(pc0), .acc_o(acc0), .state_o(state0)
    );

    acc_cpu_core #(.DATA_W(DW), .OP_W(3), .ADDR_W(AW), .START_HALTED(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run_i(run1), .mem(bus1),
        .halted_o(halted1), .zero_o(zero1), .carry_o(carry1),
        .pc_o(pc1), .acc_o(acc1), .state_o(state1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // dut1 memory: zero-wait, every location holds HLT
    assign bus1.mem_ack   = bus1.mem_req;
    assign bus1.mem_rdata = '0;

    // dut0 memory: per-access wait counts from wait_tab, spurious acks while idle
    logic [7:0] mem      [32];
    logic [7:0] load_img [32];
    int         wait_tab [256];
    logic       load_req = 1'b0;
    int         acc_idx  = 0;
    int         wcnt     = 0;
    logic       spur     = 1'b0;
    int         fetch_q[$];

    logic          s_req = 1'b0, s_ack = 1'b0, s_we = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_wdata = '0;
    logic [1:0]    s_state = '0;

    assign bus0.mem_ack   = bus0.mem_req ? (wcnt >= wait_tab[acc_idx % 256]) : spur;
    assign bus0.mem_rdata = mem[bus0.mem_addr];

    always @(negedge clk) begin
        s_req   <= bus0.mem_req;
        s_ack   <= bus0.mem_ack;
        s_we    <= bus0.mem_we;
        s_addr  <= bus0.mem_addr;
        s_wdata <= bus0.mem_wdata;
        s_state <= state0;
    end

    always @(posedge clk) begin
        spur <= 1'($urandom);
        if (load_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= load_img[i];
        end else if (rst_n && s_req && s_ack && s_we) begin
            mem[s_addr] <= s_wdata;
        end
        if (!rst_n) begin
            acc_idx <= 0;
            wcnt    <= 0;
            fetch_q.delete();
        end else if (s_req && s_ack) begin
            acc_idx <= acc_idx + 1;
            wcnt    <= 0;
            if (s_state == 2'd1) fetch_q.push_back(int'(s_addr));
        end else if (s_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Busy-cycle counter and bus stability while an access waits for ack
    int          busy = 0;
    logic        prev_hold = 1'b0;
    logic [14:0] prev_vec = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy      <= 0;
            prev_hold <= 1'b0;
        end else begin
            if (state0 == 2'd1 || state0 == 2'd2) busy <= busy + 1;
            if (prev_hold)
                check("hold", {17'd0, bus0.mem_req, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata},
                      {17'd0, prev_vec});
            prev_hold <= bus0.mem_req && !bus0.mem_ack;
            prev_vec  <= {bus0.mem_req, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata};
        end
    end

    // ISA-level reference: interprets the program instruction by instruction
    logic [7:0] ref_mem [32];
    int         ref_fetch[$];
    int         ref_pc, ref_acc, ref_carry, ref_cycles;
    bit         ref_halted;

    task automatic model_run();
        int pc = 0, acc = 0, c = 0, k = 0, cyc = 0;
        ref_fetch.delete();
        ref_halted = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = load_img[i];
        for (int step = 0; step < 64 && !ref_halted; step++) begin
            int ins, op, a;
            ref_fetch.push_back(pc);
            ins = int'(ref_mem[pc]);
            cyc += 1 + wait_tab[k];
            k++;
            pc = (pc + 1) % 32;
            op = ins / 32;
            a  = ins % 32;
            case (op)
                0: begin cyc++; ref_halted = 1'b1; end
                1: begin cyc++; if (acc == 0) pc = (pc + 1) % 32; end
                7: begin cyc++; pc = a; end
                default: begin
                    cyc += 1 + wait_tab[k];
                    k++;
                    case (op)
                        2: begin acc = acc + int'(ref_mem[a]); c = acc / 256; acc = acc % 256; end
                        3: acc = acc & int'(ref_mem[a]);
                        4: acc = acc ^ int'(ref_mem[a]);
                        5: acc = int'(ref_mem[a]);
                        default: ref_mem[a] = 8'(acc);
                    endcase
                end
            endcase
        end
        ref_pc = pc; ref_acc = acc; ref_carry = c; ref_cycles = cyc;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n    = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
        #1;
        check("rst_state0", state0, 0);
        check("rst_req0",   bus0.mem_req, 0);
        check("rst_we0",    bus0.mem_we, 0);
        check("rst_halt0",  halted0, 0);
        check("rst_pc0",    pc0, 0);
        check("rst_acc0",   acc0, 0);
        check("rst_carry0", carry0, 0);
        check("rst_state1", state1, 0);
        check("rst_halt1",  halted1, 0);
        rst_n = 1'b1;
    endtask

    task automatic clear_img(input int wmode);
        for (int i = 0; i < 32; i++) load_img[i] = 8'h00;
        for (int i = 0; i < 256; i++)
            wait_tab[i] = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
    endtask

    task automatic run_prog(input string tag);
        int n = 0;
        model_run();
        reset_dut();
        while (!halted0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({tag, "_halted"}, halted0, 1);
        check({tag, "_state"},  state0, 3);
        check({tag, "_req"},    bus0.mem_req, 0);
        check({tag, "_pc"},     pc0, ref_pc);
        check({tag, "_acc"},    acc0, ref_acc);
        check({tag, "_carry"},  carry0, ref_carry);
        check({tag, "_zero"},   zero0, (ref_acc == 0));
        check({tag, "_cycles"}, busy, ref_cycles);
        check({tag, "_nfetch"}, fetch_q.size(), ref_fetch.size());
        for (int i = 0; i < fetch_q.size() && i < ref_fetch.size(); i++)
            check({tag, "_fetch"}, fetch_q[i], ref_fetch[i]);
        for (int i = 0; i < 32; i++)
            check({tag, "_mem"}, mem[i], ref_mem[i]);
    endtask

    initial begin
        int n;
        logic any_req, all_halt;
        int exp_fetch [5] = '{0, 2, 31, 0, 1};

        clear_img(0);

        // START_HALTED instance: parked in HALT, ignores run outside HALT
        reset_dut();
        @(negedge clk);
        any_req  = 1'b0;
        all_halt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_req  = any_req | bus1.mem_req;
            all_halt = all_halt & halted1;
        end
        check("sh_no_req", any_req, 0);
        check("sh_halted", all_halt, 1);
        run1 = 1'b1;
        @(negedge clk);
        run1 = 1'b0;
        check("sh_fetch_state", state1, 1);
        check("sh_fetch_addr",  bus1.mem_addr, 0);
        check("sh_fetch_req",   bus1.mem_req, 1);
        @(negedge clk);
        check("sh_exec_state", state1, 2);
        run1 = 1'b1;
        @(negedge clk);
        run1 = 1'b0;
        check("sh_run_ignored", state1, 3);
        check("sh_pc_after",    pc1, 1);

        // LDA 10, ADD 11, STO 12, HLT with zero-wait then 3-wait memory
        for (int w = 0; w <= 3; w += 3) begin
            clear_img(w);
            load_img[0] = 8'hAA; load_img[1] = 8'h4B; load_img[2] = 8'hCC; load_img[3] = 8'h00;
            load_img[10] = 8'h05; load_img[11] = 8'hFE;
            run_prog(w == 0 ? "prog_w0" : "prog_w3");
            check("prog_sto", mem[12], 8'h03);
            check("prog_carry", carry0, 1);
            check("prog_pc", pc0, 4);
            if (w == 0) check("prog_cycles_w0", busy, 8);
        end

        // SKZ with acc zero / nonzero at pc 3
        for (int v = 0; v < 2; v++) begin
            clear_img(-1);
            load_img[0] = 8'hB4; load_img[1] = 8'hB4; load_img[2] = 8'hB4; load_img[3] = 8'h20;
            load_img[20] = 8'(v);
            run_prog("skz");
            check("skz_pc", pc0, (v == 0) ? 6 : 5);
        end

        // SKZ at address 31 wraps the skip to 1
        clear_img(-1);
        load_img[0] = 8'hFF; load_img[31] = 8'h20;
        run_prog("skz_wrap");
        check("skz_wrap_pc", pc0, 2);

        // JMP 31 then the fetch after 31 wraps to address 0
        clear_img(-1);
        load_img[0] = 8'h20; load_img[2] = 8'hFF; load_img[31] = 8'hB5; load_img[21] = 8'h05;
        run_prog("jmp_wrap");
        check("jmp_wrap_acc", acc0, 5);
        for (int i = 0; i < 5 && i < fetch_q.size(); i++) check("jmp_wrap_seq", fetch_q[i], exp_fetch[i]);

        // Random programs with random wait states
        for (int t = 0; t < 25; t++) begin
            n = 0;
            do begin
                clear_img(-1);
                for (int i = 0; i < 32; i++) load_img[i] = 8'($urandom);
                model_run();
                n++;
            end while (!ref_halted && n < 100);
            run_prog("rand");
        end

        // Reset while STO waits for ack: access aborted, no write
        clear_img(0);
        load_img[0] = 8'hB4; load_img[1] = 8'hD5; load_img[20] = 8'h5A; load_img[21] = 8'h11;
        wait_tab[3] = 10;
        reset_dut();
        n = 0;
        while (!(state0 == 2'd2 && bus0.mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_sto", (state0 == 2'd2 && bus0.mem_we), 1);
        @(negedge clk);
        check("abort_acc_before", acc0, 8'h5A);
        check("abort_req_before", bus0.mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req",   bus0.mem_req, 0);
        check("abort_acc",   acc0, 0);
        check("abort_state", state0, 0);
        @(negedge clk);
        #1;
        check("abort_no_write", mem[21], 8'h11);
        rst_n = 1'b1;
        check("abort_idle", state0, 0);
        @(negedge clk);
        check("abort_fetch_state", state0, 1);
        check("abort_fetch_addr",  bus0.mem_addr, 0);
        check("abort_fetch_req",   bus0.mem_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
`default_nettype wire
